multi_rate_divider: RTL and testbench

MULTI_RATE_DIVIDER -- requirements
Module: multi_rate_divider

---
 rtl/multi_rate_divider.sv | 155 +++++++++++++++
 tb/tb_multi_rate_divider.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: per-channel fractional step generator emitting step_count steps at rate multiplicand/dividend.
// Latency: step/busy/done are registers that reflect the decision taken on the previous rising clk edge.
// Backpressure: none; start/abort are sampled every edge. Define MRD_POSITION_EN to build the position counters.

module multi_rate_divider #(
  parameter int CHANNELS   = 4,
  parameter int COUNT_BITS = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*COUNT_BITS-1:0] multiplicand,
  input  logic [CHANNELS*COUNT_BITS-1:0] dividend,
  input  logic [CHANNELS*COUNT_BITS-1:0] step_count,
  input  logic [CHANNELS-1:0]            start,
  input  logic [CHANNELS-1:0]            abort,
  input  logic [CHANNELS-1:0]            dir,
  output logic [CHANNELS-1:0]            step,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            done,
  output logic [CHANNELS*COUNT_BITS-1:0] position
);

  localparam int CB = COUNT_BITS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CB-1:0] mult;
    logic [CB-1:0] div;
    logic [CB-1:0] cnt;
    state_t        state_q, state_d;
    logic [CB:0]   acc_q, acc_d;
    logic [CB-1:0] rem_q, rem_d;
    logic          step_q, step_d;
    logic          done_q, done_d;
    logic [CB:0]   sum;
    logic [CB:0]   div_ext;

    assign mult    = multiplicand[i*CB +: CB];
    assign div     = dividend[i*CB +: CB];
    assign cnt     = step_count[i*CB +: CB];
    // acc stays below the dividend it was built against, so one extra bit holds acc+mult.
    assign div_ext = {1'b0, div};
    assign sum     = acc_q + {1'b0, mult};

    // Next-state: abort beats start, start beats stepping; the final step also ends the run.
    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      step_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!abort[i] && start[i]) begin
            if (cnt != '0) begin
              state_d = ST_RUN;
              acc_d   = '0;
              rem_d   = cnt;
            end else begin
              // Zero-length run completes at once.
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort[i]) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            rem_d   = '0;
          end else if (start[i]) begin
            acc_d = '0;
            if (cnt != '0) begin
              rem_d = cnt;
            end else begin
              // Restarting with a zero count behaves like a zero-length run.
              state_d = ST_IDLE;
              rem_d   = '0;
              done_d  = 1'b1;
            end
          end else if (div != '0) begin
            if (mult >= div) begin
              // Rate at or above one: step every edge, no fractional remainder kept.
              step_d = 1'b1;
              acc_d  = '0;
            end else if (sum >= div_ext) begin
              step_d = 1'b1;
              acc_d  = sum - div_ext;
            end else begin
              acc_d = sum;
            end
            if (step_d) begin
              rem_d = rem_q - CB'(1);
              if (rem_q == CB'(1)) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
          // A zero dividend parks the channel in RUN with acc untouched.
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        rem_q   <= '0;
        step_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        rem_q   <= rem_d;
        step_q  <= step_d;
        done_q  <= done_d;
      end
    end

    assign step[i] = step_q;
    assign done[i] = done_q;
    assign busy[i] = (state_q == ST_RUN);

`ifdef MRD_POSITION_EN
    logic [CB-1:0] pos_q;

    // Position follows each emitted step, wrapping in two's complement.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_q <= '0;
      end else if (step_d) begin
        pos_q <= pos_q + (dir[i] ? CB'(1) : {CB{1'b1}});
      end
    end

    assign position[i*CB +: CB] = pos_q;
`endif
  end

`ifndef MRD_POSITION_EN
  // Position tracking is not built; direction has no effect.
  logic unused_dir;
  assign unused_dir = ^dir;
  assign position   = '0;
`endif

endmodule

// File: tb/tb_multi_rate_divider.sv
module tb_multi_rate_divider;
  localparam int CH = 4;
  localparam int CB = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [CH*CB-1:0]   multiplicand = '0;
  logic [CH*CB-1:0]   dividend = '0;
  logic [CH*CB-1:0]   step_count = '0;
  logic [CH-1:0]      start = '0;
  logic [CH-1:0]      abort = '0;
  logic [CH-1:0]      dir = '0;
  logic [CH-1:0]      step;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;
  logic [CH*CB-1:0]   position;

  multi_rate_divider #(.CHANNELS(CH), .COUNT_BITS(CB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .dividend     (dividend),
    .step_count   (step_count),
    .start        (start),
    .abort        (abort),
    .dir          (dir),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .position     (position)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference model: a channel running at rate m/d has emitted floor(k*m/d) steps after k
  // counting edges since its start; a step happens on edge k when that total increases.
  bit          m_run  [CH];
  longint      m_k    [CH];
  longint      m_rem  [CH];
  logic [CB-1:0] m_pos [CH];
  bit          e_step [CH];
  bit          e_done [CH];

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0; m_k[i] = 0; m_rem[i] = 0; m_pos[i] = '0; e_step[i] = 0; e_done[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    longint mv, dv, cv;
    bit s, d;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 0; m_k[i] = 0; m_rem[i] = 0; m_pos[i] = '0; e_step[i] = 0; e_done[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        mv = longint'(multiplicand[i*CB +: CB]);
        dv = longint'(dividend[i*CB +: CB]);
        cv = longint'(step_count[i*CB +: CB]);
        s = 0;
        d = 0;
        if (!m_run[i]) begin
          if (!abort[i] && start[i]) begin
            if (cv != 0) begin m_run[i] = 1; m_k[i] = 0; m_rem[i] = cv; end
            else d = 1;
          end
        end else if (abort[i]) begin
          m_run[i] = 0;
        end else if (start[i]) begin
          m_k[i] = 0;
          if (cv != 0) m_rem[i] = cv;
          else begin m_run[i] = 0; d = 1; end
        end else if (dv != 0) begin
          m_k[i]++;
          if ((m_k[i] * mv) / dv != ((m_k[i] - 1) * mv) / dv) begin
            s = 1;
            m_rem[i]--;
            if (m_rem[i] == 0) begin d = 1; m_run[i] = 0; end
          end
        end
`ifdef MRD_POSITION_EN
        if (s) m_pos[i] = dir[i] ? m_pos[i] + 32'd1 : m_pos[i] - 32'd1;
`endif
        e_step[i] = s;
        e_done[i] = d;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("step[%0d]", i), 64'(step[i]), 64'(e_step[i]));
      chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_run[i]));
      chk($sformatf("done[%0d]", i), 64'(done[i]), 64'(e_done[i]));
      chk($sformatf("position[%0d]", i), 64'(position[i*CB +: CB]), 64'(m_pos[i]));
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic [CB-1:0] m, input logic [CB-1:0] d, input logic [CB-1:0] c);
    multiplicand[i*CB +: CB] = m;
    dividend[i*CB +: CB]     = d;
    step_count[i*CB +: CB]   = c;
  endtask

  initial begin
    int nsteps, done_at, step_at_done, ndone;
    logic [7:0] sp, dp;
    logic [CB-1:0] rm, rd;

    // Reset state.
    repeat (3) cycle();
    chk("reset_step", 64'(step), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_position", 64'(position[63:0]), 64'(0));
    rst_n = 1'b1;
    cycle();

    // Position: 5 up, 7 down on channel 1.
    set_ch(1, 1, 1, 12);
    dir[1] = 1'b1;
    start[1] = 1'b1;
    cycle();
    start[1] = 1'b0;
    repeat (5) cycle();
    dir[1] = 1'b0;
    repeat (7) cycle();
`ifdef MRD_POSITION_EN
    chk("pos_after_5up_7down", 64'(position[CB +: CB]), 64'(32'hFFFF_FFFE));
`else
    chk("pos_disabled", 64'(position[CB +: CB]), 64'(0));
`endif
    chk("pos_run_busy", 64'(busy[1]), 64'(0));

    // Rate 2/3, 20 steps.
    set_ch(0, 2, 3, 20);
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    nsteps = 0; done_at = -1; step_at_done = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (step[0]) nsteps++;
      if (done[0] && done_at < 0) begin done_at = c; step_at_done = int'(step[0]); end
    end
    chk("r23_steps", 64'(nsteps), 64'(20));
    chk("r23_done_cycle", 64'(done_at), 64'(30));
    chk("r23_done_with_step", 64'(step_at_done), 64'(1));
    chk("r23_busy_after", 64'(busy[0]), 64'(0));

    // Rate 5/5, 4 steps back to back.
    set_ch(0, 5, 5, 4);
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    sp = '0; dp = '0;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      sp[c] = step[0];
      dp[c] = done[0];
    end
    chk("r55_step_pattern", 64'(sp), 64'(8'h1E));
    chk("r55_done_pattern", 64'(dp), 64'(8'h10));
    chk("r55_busy_after", 64'(busy[0]), 64'(0));

    // Zero step count.
    set_ch(0, 1, 1, 0);
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    chk("zero_done", 64'(done[0]), 64'(1));
    chk("zero_step", 64'(step[0]), 64'(0));
    chk("zero_busy", 64'(busy[0]), 64'(0));
    cycle();
    chk("zero_done_gone", 64'(done[0]), 64'(0));

    // Abort on the edge of the final step.
    set_ch(0, 1, 1, 3);
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    repeat (2) cycle();
    abort[0] = 1'b1;
    cycle();
    abort[0] = 1'b0;
    chk("abort_step", 64'(step[0]), 64'(0));
    chk("abort_done", 64'(done[0]), 64'(0));
    chk("abort_busy", 64'(busy[0]), 64'(0));

    // Restart mid-run, on an edge that would otherwise step.
    set_ch(0, 1, 2, 10);
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    repeat (3) cycle();
    set_ch(0, 1, 2, 3);
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    chk("restart_no_step", 64'(step[0]), 64'(0));
    chk("restart_busy", 64'(busy[0]), 64'(1));
    nsteps = 0; ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (step[0]) nsteps++;
      if (done[0]) begin ndone++; done_at = c; end
    end
    chk("restart_steps", 64'(nsteps), 64'(3));
    chk("restart_done_count", 64'(ndone), 64'(1));
    chk("restart_done_cycle", 64'(done_at), 64'(6));

    // Four channels concurrently: 1/1, 1/2, 1/3, 1/7 for 21 edges.
    set_ch(0, 1, 1, 100);
    set_ch(1, 1, 2, 100);
    set_ch(2, 1, 3, 100);
    set_ch(3, 1, 7, 100);
    start = '1;
    cycle();
    start = '0;
    begin
      int cnt[CH];
      for (int i = 0; i < CH; i++) cnt[i] = 0;
      for (int c = 1; c <= 21; c++) begin
        cycle();
        for (int i = 0; i < CH; i++) if (step[i]) cnt[i]++;
      end
      chk("multi_ch0", 64'(cnt[0]), 64'(21));
      chk("multi_ch1", 64'(cnt[1]), 64'(10));
      chk("multi_ch2", 64'(cnt[2]), 64'(7));
      chk("multi_ch3", 64'(cnt[3]), 64'(3));
    end
    abort = '1;
    cycle();
    abort = '0;
    chk("multi_abort_busy", 64'(busy), 64'(0));

    // Reset mid-run clears everything at once; start after release works.
    set_ch(2, 1, 1, 50);
    start[2] = 1'b1;
    cycle();
    start[2] = 1'b0;
    repeat (3) cycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_step", 64'(step), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_position", 64'(position[127:64]), 64'(0));
    @(negedge clk);
    set_ch(2, 1, 1, 5);
    start[2] = 1'b1;
    rst_n = 1'b1;
    cycle();
    start[2] = 1'b0;
    chk("post_reset_start", 64'(busy[2]), 64'(1));
    abort[2] = 1'b1;
    cycle();
    abort[2] = 1'b0;

    // Randomized traffic; m/d only change while a channel is idle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < CH; i++) begin
        start[i] = 1'b0;
        abort[i] = 1'b0;
        if (!m_run[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 9))
              0: begin rm = $urandom; rd = $urandom; end
              1: begin rm = CB'($urandom_range(0, 5)); rd = '0; end
              default: begin rm = CB'($urandom_range(0, 6)); rd = CB'($urandom_range(1, 8)); end
            endcase
            set_ch(i, rm, rd, CB'($urandom_range(0, 12)));
            start[i] = 1'b1;
          end
        end else begin
          case ($urandom_range(0, 99))
            0, 1, 2: abort[i] = 1'b1;
            3: begin abort[i] = 1'b1; start[i] = 1'b1; end
            4, 5: begin
              step_count[i*CB +: CB] = CB'($urandom_range(0, 12));
              start[i] = 1'b1;
            end
            default: ;
          endcase
        end
        dir[i] = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    start = '0;
    abort = '1;
    cycle();
    abort = '0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
